brick_ram_sequencer: RTL

Owns the 256×1 brick RAM and shares it between three requesters: the video display fetch, the ball/brick hit clear, and the game-start fill that sets every brick of a player bank. The block sits between the playfield timing/collision logic and the brick RAM. It grants exactly one RAM access per clock: display reads first, fill writes second, hit read-modify-writes last. With the count feature compiled in, it also tracks the bricks remaining per player.

---
 rtl/brick_ram_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/brick_ram_sequencer.sv
// Arbiter for the 256x1 brick RAM: display reads, bank fill writes and hit read-modify-writes.
// Optional per-bank brick counters are built when BRICK_COUNT_EN is defined.
module brick_ram_sequencer #(
   parameter int ADDR_W    = 7,
   parameter int HIT_DEPTH = 2
) (
   input  logic              CLK_DRV,
   input  logic              RESET,
   input  logic              DISP_REQ,
   input  logic [ADDR_W-1:0] DISP_ADDR,
   input  logic              PLAYER,
   output logic              DISP_DATA,
   output logic              DISP_VALID,
   input  logic              HIT_REQ,
   input  logic [ADDR_W-1:0] HIT_ADDR,
   output logic              HIT_ACK,
   output logic              HIT_SCORE,
   output logic              HIT_OVF,
   input  logic              FILL_REQ,
   output logic              FILL_BUSY,
   output logic [ADDR_W:0]   RAM_ADDR,
   output logic              RAM_WE,
   output logic              RAM_DIN,
   input  logic              RAM_DOUT,
   output logic [ADDR_W:0]   BRICKS_LEFT,
   output logic              ALL_CLEAR
);
   // state  | meaning
   // IDLE   | waiting for a pending fill or a queued hit
   // FILL   | writing 1 to {fill_bank, fill_ctr}, one brick per granted cycle
   // HIT_RD | reading the brick addressed by the queue head
   // HIT_WR | clearing the brick if set, acknowledging and popping the hit
   typedef enum logic [1:0] {IDLE, FILL, HIT_RD, HIT_WR} state_t;

   localparam logic [1:0]        LAST_PTR  = 2'(HIT_DEPTH - 1);
   localparam logic [2:0]        DEPTH_CNT = 3'(HIT_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_FILL = '1;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     q_mem [4];
   logic [1:0]          rd_ptr, wr_ptr;
   logic [2:0]          q_cnt;
   logic [ADDR_W-1:0]   fill_ctr;
   logic                fill_bank, fill_pend;
   logic [ADDR_W:0]     last_addr;
   logic                disp_valid_q, hit_rd_q, hit_bit_q;

   logic                stall, fill_busy, fill_req_acc, fill_start, fill_last;
   logic                hit_blocked, q_full, push_ok, pop, hit_bit;
   logic [ADDR_W:0]     q_head;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   assign stall        = DISP_REQ;
   assign fill_busy    = (state_q == FILL);
   assign fill_req_acc = FILL_REQ && !fill_busy && !fill_pend;
   assign fill_start   = (state_q == IDLE) && !stall && (fill_pend || fill_req_acc);
   assign fill_last    = fill_busy && !stall && (fill_ctr == LAST_FILL);
   // a fill request in the same cycle always wins over a hit request
   assign hit_blocked  = fill_busy || FILL_REQ || fill_start;
   assign q_full       = (q_cnt == DEPTH_CNT);
   assign q_head       = q_mem[rd_ptr];
   // RAM_DOUT is only the hit data in the first HIT_WR cycle; after a stall use the saved bit
   assign hit_bit      = hit_rd_q ? RAM_DOUT : hit_bit_q;
   assign pop          = (state_q == HIT_WR) && !stall;
   assign push_ok      = HIT_REQ && !hit_blocked && (!q_full || pop);

   assign HIT_OVF    = HIT_REQ && !hit_blocked && q_full && !pop;
   assign HIT_ACK    = pop;
   assign HIT_SCORE  = pop && hit_bit;
   assign FILL_BUSY  = fill_busy;
   assign DISP_VALID = disp_valid_q;
   assign DISP_DATA  = disp_valid_q && RAM_DOUT;

   always_comb begin
      state_d  = state_q;
      RAM_ADDR = last_addr;
      RAM_WE   = 1'b0;
      RAM_DIN  = 1'b0;
      if (stall) begin
         RAM_ADDR = {PLAYER, DISP_ADDR};
      end else begin
         case (state_q)
            IDLE: begin
               if (fill_pend || fill_req_acc)
                  state_d = FILL;
               else if (q_cnt != 3'd0 || push_ok)
                  state_d = HIT_RD;
            end
            FILL: begin
               RAM_ADDR = {fill_bank, fill_ctr};
               RAM_WE   = 1'b1;
               RAM_DIN  = 1'b1;
               if (fill_last)
                  state_d = IDLE;
            end
            HIT_RD: begin
               RAM_ADDR = q_head;
               state_d  = HIT_WR;
            end
            HIT_WR: begin
               RAM_ADDR = q_head;
               RAM_WE   = hit_bit;
               if (fill_pend || fill_req_acc)
                  state_d = IDLE;
               else if (q_cnt > 3'd1 || push_ok)
                  state_d = HIT_RD;
               else
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_DRV) begin
      if (RESET) begin
         state_q      <= IDLE;
         last_addr    <= '0;
         disp_valid_q <= 1'b0;
         hit_rd_q     <= 1'b0;
         hit_bit_q    <= 1'b0;
         fill_ctr     <= '0;
         fill_pend    <= 1'b0;
         fill_bank    <= 1'b0;
         q_cnt        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
      end else begin
         state_q      <= state_d;
         last_addr    <= RAM_ADDR;
         disp_valid_q <= DISP_REQ;
         hit_rd_q     <= (state_q == HIT_RD) && !stall;
         if (state_q == HIT_WR)
            hit_bit_q <= hit_bit;
         if (fill_busy && !stall)
            fill_ctr <= fill_ctr + ADDR_W'(1);
         if (fill_start)
            fill_pend <= 1'b0;
         else if (fill_req_acc)
            fill_pend <= 1'b1;
         if (fill_req_acc)
            fill_bank <= PLAYER;
         if (fill_start) begin
            q_cnt  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
               rd_ptr <= ptr_inc(rd_ptr);
            q_cnt <= q_cnt + 3'(push_ok) - 3'(pop);
         end
      end
   end

   always_ff @(posedge CLK_DRV) begin
      if (push_ok && !RESET)
         q_mem[wr_ptr] <= {PLAYER, HIT_ADDR};
   end

`ifdef BRICK_COUNT_EN
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0][ADDR_W:0] cnt_q, cnt_d;
   logic [ADDR_W:0]      bricks_q;
   logic                 all_clear_q;

   always_comb begin
      cnt_d = cnt_q;
      if (fill_last)
         cnt_d[fill_bank] = FULL_CNT;
      if (HIT_SCORE && cnt_q[q_head[ADDR_W]] != '0)
         cnt_d[q_head[ADDR_W]] = cnt_q[q_head[ADDR_W]] - (ADDR_W+1)'(1);
   end

   always_ff @(posedge CLK_DRV) begin
      if (RESET) begin
         cnt_q       <= '0;
         bricks_q    <= '0;
         all_clear_q <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         bricks_q    <= cnt_d[PLAYER];
         all_clear_q <= (cnt_d[PLAYER] == '0);
      end
   end

   assign BRICKS_LEFT = bricks_q;
   assign ALL_CLEAR   = all_clear_q;
`else
   assign BRICKS_LEFT = '0;
   assign ALL_CLEAR   = 1'b0;
`endif

endmodule
